// File: rtl/btn_cmd_pkg.sv
// Shared types for the button command controller: FSM state encoding and
// the debounce counter width helper.
package btn_cmd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_ISSUE    = 2'd2,
        ST_WAIT_REL = 2'd3
    } state_e;

    // Wide enough to hold the value "cycles" itself, so the counter saturates at the threshold.
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/btn_sync.sv
// NUM_BTN-wide two-flop synchroniser for raw active-low buttons.
// Flops reset to all-ones, i.e. every button released.
module btn_sync #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/btn_cmd_ctrl.sv
// Debounced push-button to one-hot command controller with ready/valid handshake.
// Define BTN_CMD_SYNC_EN to insert a two-flop synchroniser ahead of the debouncer.
module btn_cmd_ctrl
    import btn_cmd_pkg::*;
#(
    parameter int NUM_BTN         = 3,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] buttons,
    input  logic               cmd_ready,
    output logic               cmd_valid,
    output logic [NUM_BTN-1:0] cmd_id,
    output logic               multi_press,
    output logic               busy
);

    localparam int            CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [NUM_BTN-1:0] btn_s;
    logic [NUM_BTN-1:0] p;
    logic               p_zero;
    logic               p_onehot;
    logic               p_multi;

`ifdef BTN_CMD_SYNC_EN
    btn_sync #(
        .WIDTH(NUM_BTN)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (buttons),
        .q_o  (btn_s)
    );
`else
    assign btn_s = buttons;
`endif

    assign p        = ~btn_s;
    assign p_zero   = (p == '0);
    assign p_onehot = $onehot(p);
    assign p_multi  = !p_zero && !p_onehot;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NUM_BTN-1:0] cand_q, cand_d;
    logic               multi_prev_q;
    logic               multi_press_q, multi_press_d;
    logic [CW-1:0]      cnt_inc;

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        case (state_q)
            ST_IDLE: begin
                if (p_onehot) begin
                    cand_d  = p;
                    cnt_d   = CNT_ONE;
                    state_d = (DEBOUNCE_CYCLES == 1) ? ST_ISSUE : ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                if (p == cand_q) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_MAX) state_d = ST_ISSUE;
                end else if (p_onehot) begin
                    cand_d = p;
                    cnt_d  = CNT_ONE;
                end else begin
                    // Released or multi-bit: abandon the candidate.
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (cmd_ready) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_REL;
                end
            end
            ST_WAIT_REL: begin
                if (p_zero) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_MAX) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Edge-detect on the multi-bit condition so a held chord reports only once.
    assign multi_press_d = ((state_q == ST_IDLE) || (state_q == ST_DEBOUNCE))
                           && p_multi && !multi_prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            cand_q        <= '0;
            multi_prev_q  <= 1'b0;
            multi_press_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cand_q        <= cand_d;
            multi_prev_q  <= p_multi;
            multi_press_q <= multi_press_d;
        end
    end

    assign cmd_valid   = (state_q == ST_ISSUE);
    assign cmd_id      = cmd_valid ? cand_q : '0;
    assign busy        = (state_q != ST_IDLE);
    assign multi_press = multi_press_q;

endmodule

// File: tb/tb_btn_cmd_ctrl.sv
// Directed bench for btn_cmd_ctrl (NUM_BTN=3, DEBOUNCE_CYCLES=4); latencies
// shift by two cycles when BTN_CMD_SYNC_EN is defined.
module tb_btn_cmd_ctrl;

    localparam int NB = 3;
    localparam int DC = 4;
`ifdef BTN_CMD_SYNC_EN
    localparam int S = 2;
`else
    localparam int S = 0;
`endif
    localparam int LAT = DC + S;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NB-1:0] buttons = '1;
    logic          cmd_ready = 1'b1;
    logic          cmd_valid;
    logic [NB-1:0] cmd_id;
    logic          multi_press;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int vld_cycles = 0;
    int mp_cycles = 0;
    int v0, m0;

    btn_cmd_ctrl #(
        .NUM_BTN        (NB),
        .DEBOUNCE_CYCLES(DC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .buttons    (buttons),
        .cmd_ready  (cmd_ready),
        .cmd_valid  (cmd_valid),
        .cmd_id     (cmd_id),
        .multi_press(multi_press),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_valid === 1'b1) vld_cycles++;
        if (multi_press === 1'b1) mp_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int i = 0;
        while (busy === 1'b1 && i < budget) begin
            step();
            i++;
        end
        check("idle_reached", 32'(busy), 32'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step(2);
        check("rst_valid", 32'(cmd_valid), 32'(0));
        check("rst_id",    32'(cmd_id),    32'(0));
        check("rst_busy",  32'(busy),      32'(0));
        check("rst_multi", 32'(multi_press), 32'(0));
        rst_n = 1'b1;
        step(2);

        // Single press held 20 cycles, ready high
        v0 = vld_cycles;
        buttons = 3'b110;
        step(LAT - 1);
        check("sp_pre_valid", 32'(cmd_valid), 32'(0));
        step();
        check("sp_valid", 32'(cmd_valid), 32'(1));
        check("sp_id",    32'(cmd_id),    32'(3'b001));
        step();
        check("sp_pulse_end", 32'(cmd_valid), 32'(0));
        check("sp_id_zero",   32'(cmd_id),    32'(0));
        check("sp_busy_held", 32'(busy),      32'(1));
        step(20 - LAT - 1);
        buttons = 3'b111;
        step(3 + S);
        check("sp_busy_rel3", 32'(busy), 32'(1));
        step();
        check("sp_busy_rel4", 32'(busy), 32'(0));
        check("sp_cmd_count", 32'(vld_cycles - v0), 32'(1));

        // Bounce: 2 pressed, 1 released, 4 pressed
        v0 = vld_cycles;
        buttons = 3'b101;
        step(2);
        buttons = 3'b111;
        step(1);
        buttons = 3'b101;
        step(3 + S);
        check("bn_pre_valid", 32'(cmd_valid), 32'(0));
        step();
        check("bn_valid", 32'(cmd_valid), 32'(1));
        check("bn_id",    32'(cmd_id),    32'(3'b010));
        step(3);
        buttons = 3'b111;
        wait_idle(20);
        check("bn_cmd_count", 32'(vld_cycles - v0), 32'(1));

        // Multi-press chord held 10 cycles
        v0 = vld_cycles;
        m0 = mp_cycles;
        buttons = 3'b100;
        step(10);
        buttons = 3'b111;
        step(2 + S);
        check("mp_pulses",  32'(mp_cycles - m0),  32'(1));
        check("mp_no_cmd",  32'(vld_cycles - v0), 32'(0));
        check("mp_idle",    32'(busy),            32'(0));

        // Backpressure with release during ISSUE
        cmd_ready = 1'b0;
        buttons = 3'b011;
        step(LAT);
        check("bp_valid", 32'(cmd_valid), 32'(1));
        check("bp_id",    32'(cmd_id),    32'(3'b100));
        buttons = 3'b111;
        for (int i = 0; i < 7; i++) begin
            step();
            check("bp_hold_valid", 32'(cmd_valid), 32'(1));
            check("bp_hold_id",    32'(cmd_id),    32'(3'b100));
        end
        cmd_ready = 1'b1;
        step();
        check("bp_accepted", 32'(cmd_valid), 32'(0));
        check("bp_busy",     32'(busy),      32'(1));
        step(3);
        check("bp_busy_rel3", 32'(busy), 32'(1));
        step();
        check("bp_busy_rel4", 32'(busy), 32'(0));

        // Reset while in ISSUE, button still held
        cmd_ready = 1'b0;
        buttons = 3'b110;
        step(LAT);
        check("ri_valid", 32'(cmd_valid), 32'(1));
        rst_n = 1'b0;
        step();
        check("ri_drop_valid", 32'(cmd_valid), 32'(0));
        check("ri_drop_busy",  32'(busy),      32'(0));
        check("ri_drop_id",    32'(cmd_id),    32'(0));
        rst_n = 1'b1;
        step(LAT - 1);
        check("ri_pre_valid", 32'(cmd_valid), 32'(0));
        step();
        check("ri_reissue", 32'(cmd_valid), 32'(1));
        check("ri_id",      32'(cmd_id),    32'(3'b001));
        cmd_ready = 1'b1;
        step();
        buttons = 3'b111;
        wait_idle(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
